// File: rtl/execute_pkg.sv
// Shared types for the LEGv8 execute stage: ALU op codes, forwarding selects, FSM states.
package execute_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_NOR   = 4'b1100,
    OP_MUL   = 4'b1000
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } ex_state_t;

endpackage

// File: rtl/execute_pipe_if.sv
// ID/EX operand bus, decode handshake and EX/MEM result fields of the execute stage.
interface execute_pipe_if #(parameter int unsigned N = 64);
  logic         in_valid_E;
  logic         in_ready_E;
  logic         flush_E;
  logic         AluSrc;
  logic [3:0]   AluControl;
  logic [1:0]   ForwardA;
  logic [1:0]   ForwardB;
  logic [N-1:0] PC_E;
  logic [N-1:0] signImm_E;
  logic [N-1:0] readData1_E;
  logic [N-1:0] readData2_E;
  logic [N-1:0] result_W;
  logic         out_valid_M;
  logic [N-1:0] PCBranch_M;
  logic [N-1:0] aluResult_M;
  logic [N-1:0] writeData_M;
  logic         zero_M;

  modport master (
    output in_valid_E, flush_E, AluSrc, AluControl, ForwardA, ForwardB,
           PC_E, signImm_E, readData1_E, readData2_E, result_W,
    input  in_ready_E, out_valid_M, PCBranch_M, aluResult_M, writeData_M, zero_M
  );

  modport slave (
    input  in_valid_E, flush_E, AluSrc, AluControl, ForwardA, ForwardB,
           PC_E, signImm_E, readData1_E, readData2_E, result_W,
    output in_ready_E, out_valid_M, PCBranch_M, aluResult_M, writeData_M, zero_M
  );
endinterface

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, low N bits of the product.
module mul_iter #(parameter int unsigned N = 64) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] product
);
  localparam int unsigned CW = $clog2(N);

  logic         busy_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0] acc_q;
  logic [N-1:0] mcand_q;
  logic [N-1:0] mplr_q;

  // Product is the accumulator after the current iteration, so the final value
  // is available in the same cycle that done is raised.
  assign product = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign done    = busy_q && (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
    end else if (start) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= a;
      mplr_q  <= b;
    end else if (busy_q) begin
      acc_q   <= product;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q + CW'(1);
      busy_q  <= ~done;
    end
  end
endmodule

// File: rtl/mux2.sv
// Generic two-input multiplexer.
module mux2 #(parameter int unsigned W = 64) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         s,
  output logic [W-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

// File: rtl/execute_pipe.sv
// LEGv8 execute stage with forwarding, decode handshake, flush and an iterative MUL;
// owns the EX/MEM register for ALU result, zero flag, branch target and store data.
module execute_pipe import execute_pkg::*; #(parameter int unsigned N = 64) (
  input  logic         clk,
  input  logic         reset,
  execute_pipe_if.slave ex
);
  ex_state_t    state_q, state_d;
  logic         ready_q;
  logic [N-1:0] fwd_a, fwd_b, src_b, alu_y, branch_tgt;
  logic [N-1:0] tgt_q, st_q;
  logic         accept, is_mul;
  logic         load_alu, load_mul, mul_start, valid_d;
  logic         mul_done;
  logic [N-1:0] mul_product;

  always_comb begin
    fwd_a = ex.readData1_E;
    case (ex.ForwardA)
      FWD_M:   fwd_a = ex.aluResult_M;
      FWD_W:   fwd_a = ex.result_W;
      default: fwd_a = ex.readData1_E;
    endcase
  end

  always_comb begin
    fwd_b = ex.readData2_E;
    case (ex.ForwardB)
      FWD_M:   fwd_b = ex.aluResult_M;
      FWD_W:   fwd_b = ex.result_W;
      default: fwd_b = ex.readData2_E;
    endcase
  end

  mux2 #(.W(N)) u_alu_src (
    .d0 (fwd_b),
    .d1 (ex.signImm_E),
    .s  (ex.AluSrc),
    .y  (src_b)
  );

  // Single-cycle ALU; MUL is produced by the iterative engine instead.
  always_comb begin
    alu_y = '0;
    case (ex.AluControl)
      OP_AND:   alu_y = fwd_a & src_b;
      OP_OR:    alu_y = fwd_a | src_b;
      OP_ADD:   alu_y = fwd_a + src_b;
      OP_SUB:   alu_y = fwd_a - src_b;
      OP_PASSB: alu_y = src_b;
      OP_NOR:   alu_y = ~(fwd_a | src_b);
      default:  alu_y = '0;
    endcase
  end

  assign branch_tgt = ex.PC_E + (ex.signImm_E << 2);
  assign is_mul     = (ex.AluControl == OP_MUL);
  assign accept     = ex.in_valid_E & ready_q & ~ex.flush_E;

  mul_iter #(.N(N)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (ex.flush_E),
    .a       (fwd_a),
    .b       (src_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    mul_start = 1'b0;
    valid_d   = 1'b0;
    if (ex.flush_E) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mul_start = 1'b1;
              state_d   = MUL;
            end else begin
              load_alu = 1'b1;
              valid_d  = 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            load_mul = 1'b1;
            valid_d  = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
    end
  end

  assign ex.in_ready_E = ready_q;

  // EX/MEM register; target and store data of a MUL are held until it retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex.out_valid_M <= 1'b0;
      ex.aluResult_M <= '0;
      ex.zero_M      <= 1'b0;
      ex.PCBranch_M  <= '0;
      ex.writeData_M <= '0;
      tgt_q          <= '0;
      st_q           <= '0;
    end else begin
      ex.out_valid_M <= valid_d;
      if (mul_start) begin
        tgt_q <= branch_tgt;
        st_q  <= fwd_b;
      end
      if (load_alu) begin
        ex.aluResult_M <= alu_y;
        ex.zero_M      <= (alu_y == '0);
        ex.PCBranch_M  <= branch_tgt;
        ex.writeData_M <= fwd_b;
      end else if (load_mul) begin
        ex.aluResult_M <= mul_product;
        ex.zero_M      <= (mul_product == '0);
        ex.PCBranch_M  <= tgt_q;
        ex.writeData_M <= st_q;
      end
    end
  end
endmodule

// File: tb/tb_execute_pipe.sv
// Self-checking bench for execute_pipe: directed vectors plus a cycle-level reference model.
module tb_execute_pipe;
  localparam int unsigned N = 64;

  logic clk;
  logic reset;
  int   checks;
  int   passes;
  logic cmp_en;

  execute_pipe_if #(.N(N)) bus ();

  execute_pipe #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .ex    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: outputs derived from the stage's rules with plain arithmetic.
  logic         m_valid, m_ready, m_zero, m_busy;
  logic [N-1:0] m_alu, m_pcb, m_wd, m_prod, m_tgt, m_st;
  int           m_rem;

  function automatic logic [N-1:0] pick(input logic [1:0] sel, input logic [N-1:0] rf,
                                        input logic [N-1:0] mem, input logic [N-1:0] wb);
    if (sel == 2'b10) return mem;
    if (sel == 2'b01) return wb;
    return rf;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] a, fb, b, r;
    if (reset) begin
      m_valid = 0; m_ready = 1; m_zero = 0; m_busy = 0; m_rem = 0;
      m_alu = '0; m_pcb = '0; m_wd = '0; m_prod = '0; m_tgt = '0; m_st = '0;
    end else if (bus.flush_E) begin
      m_valid = 0; m_ready = 1; m_busy = 0;
    end else if (m_busy) begin
      m_rem--;
      m_valid = 0;
      if (m_rem == 0) begin
        m_alu = m_prod; m_zero = (m_prod == 0); m_pcb = m_tgt; m_wd = m_st;
        m_valid = 1; m_busy = 0; m_ready = 1;
      end
    end else if (bus.in_valid_E) begin
      a  = pick(bus.ForwardA, bus.readData1_E, m_alu, bus.result_W);
      fb = pick(bus.ForwardB, bus.readData2_E, m_alu, bus.result_W);
      b  = bus.AluSrc ? bus.signImm_E : fb;
      if (bus.AluControl == 4'b1000) begin
        m_prod = a * b;
        m_tgt  = bus.PC_E + bus.signImm_E * 4;
        m_st   = fb;
        m_rem  = N; m_busy = 1; m_ready = 0; m_valid = 0;
      end else begin
        case (bus.AluControl)
          4'b0000: r = a & b;
          4'b0001: r = a | b;
          4'b0010: r = a + b;
          4'b0110: r = a - b;
          4'b0111: r = b;
          4'b1100: r = ~(a | b);
          default: r = '0;
        endcase
        m_alu = r; m_zero = (r == 0); m_pcb = bus.PC_E + bus.signImm_E * 4; m_wd = fb;
        m_valid = 1;
      end
    end else begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_out_valid", N'(bus.out_valid_M), N'(m_valid));
      chk("cyc_in_ready", N'(bus.in_ready_E), N'(m_ready));
      chk("cyc_zero", N'(bus.zero_M), N'(m_zero));
      chk("cyc_alu", bus.aluResult_M, m_alu);
      chk("cyc_pcbranch", bus.PCBranch_M, m_pcb);
      chk("cyc_writedata", bus.writeData_M, m_wd);
    end
  end

  task automatic set_ops(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] imm, input logic [N-1:0] pc, input logic src,
                         input logic [1:0] fa, input logic [1:0] fb);
    bus.AluControl  = op;
    bus.readData1_E = a;
    bus.readData2_E = b;
    bus.signImm_E   = imm;
    bus.PC_E        = pc;
    bus.AluSrc      = src;
    bus.ForwardA    = fa;
    bus.ForwardB    = fb;
  endtask

  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] imm, input logic [N-1:0] pc, input logic src,
                       input logic [1:0] fa, input logic [1:0] fb);
    set_ops(op, a, b, imm, pc, src, fa, fb);
    bus.in_valid_E = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_E = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid_M && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    checks = 0; passes = 0; cmp_en = 0;
    reset = 1'b1;
    bus.in_valid_E = 1'b0;
    bus.flush_E    = 1'b0;
    bus.result_W   = 64'd100;
    set_ops(4'b0000, '0, '0, '0, '0, 1'b0, 2'b00, 2'b00);
    @(posedge clk); #1;
    cmp_en = 1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", N'(bus.out_valid_M), 64'd0);
    chk("rst_in_ready", N'(bus.in_ready_E), 64'd1);
    chk("rst_alu", bus.aluResult_M, 64'd0);
    chk("rst_pcbranch", bus.PCBranch_M, 64'd0);
    chk("rst_writedata", bus.writeData_M, 64'd0);
    chk("rst_zero", N'(bus.zero_M), 64'd0);

    issue(4'b0010, 64'd5, 64'd9, 64'd3, 64'h100, 1'b1, 2'b00, 2'b00);
    chk("add_alu", bus.aluResult_M, 64'd8);
    chk("add_pcbranch", bus.PCBranch_M, 64'h10C);
    chk("add_zero", N'(bus.zero_M), 64'd0);
    chk("add_valid", N'(bus.out_valid_M), 64'd1);
    chk("add_wdata", bus.writeData_M, 64'd9);

    issue(4'b0110, 64'd7, 64'd7, 64'd0, 64'd0, 1'b0, 2'b00, 2'b00);
    chk("sub_alu", bus.aluResult_M, 64'd0);
    chk("sub_zero", N'(bus.zero_M), 64'd1);
    issue(4'b0010, 64'd55, 64'd0, 64'd4, 64'd0, 1'b1, 2'b10, 2'b00);
    chk("fwdm_add_alu", bus.aluResult_M, 64'd4);
    chk("fwdm_add_valid", N'(bus.out_valid_M), 64'd1);

    issue(4'b0000, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 1'b0, 2'b00, 2'b00);
    chk("and_alu", bus.aluResult_M, 64'hF000);
    issue(4'b0001, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 1'b0, 2'b00, 2'b00);
    chk("or_alu", bus.aluResult_M, 64'hFFF0);
    issue(4'b0111, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 1'b0, 2'b00, 2'b00);
    chk("passb_alu", bus.aluResult_M, 64'hFF00);
    issue(4'b1100, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 1'b0, 2'b00, 2'b00);
    chk("nor_alu", bus.aluResult_M, 64'hFFFF_FFFF_FFFF_000F);
    issue(4'b0011, 64'd3, 64'd4, 64'd0, 64'd0, 1'b0, 2'b00, 2'b00);
    chk("badop_alu", bus.aluResult_M, 64'd0);
    chk("badop_zero", N'(bus.zero_M), 64'd1);
    issue(4'b0010, 64'd1, 64'd2, 64'd0, 64'd0, 1'b0, 2'b00, 2'b01);
    chk("fwdw_alu", bus.aluResult_M, 64'd101);
    chk("fwdw_wdata", bus.writeData_M, 64'd100);
    issue(4'b0110, 64'd10, 64'd3, 64'd0, 64'd0, 1'b0, 2'b11, 2'b11);
    chk("fwd11_alu", bus.aluResult_M, 64'd7);
    issue(4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd8, 1'b0, 2'b00, 2'b00);
    chk("sub_wrap_alu", bus.aluResult_M, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("neg_imm_pcbranch", bus.PCBranch_M, 64'd4);

    // Long multiply with a second MUL held by decode through the stall.
    issue(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd2, 64'h40, 1'b0, 2'b00, 2'b00);
    chk("mul_ready_low", N'(bus.in_ready_E), 64'd0);
    set_ops(4'b1000, 64'd5, 64'd5, 64'd0, 64'd0, 1'b0, 2'b00, 2'b00);
    bus.in_valid_E = 1'b1;
    wait_valid(cyc);
    chk("mul_latency", 64'(cyc), 64'd64);
    chk("mul_alu", bus.aluResult_M, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("mul_pcbranch", bus.PCBranch_M, 64'h48);
    chk("mul_wdata", bus.writeData_M, 64'd3);
    @(posedge clk); #1;
    bus.in_valid_E = 1'b0;
    chk("mul_valid_pulse", N'(bus.out_valid_M), 64'd0);
    chk("mul2_accepted", N'(bus.in_ready_E), 64'd0);
    wait_valid(cyc);
    chk("mul2_latency", 64'(cyc), 64'd64);
    chk("mul2_alu", bus.aluResult_M, 64'd25);
    @(posedge clk); #1;
    chk("mul2_ready_back", N'(bus.in_ready_E), 64'd1);

    // Multiply aborted by flush at iteration 10.
    issue(4'b1000, 64'd6, 64'd7, 64'd0, 64'd0, 1'b0, 2'b00, 2'b00);
    repeat (9) @(posedge clk);
    #1 bus.flush_E = 1'b1;
    @(posedge clk); #1;
    bus.flush_E = 1'b0;
    chk("flush_valid", N'(bus.out_valid_M), 64'd0);
    chk("flush_ready", N'(bus.in_ready_E), 64'd1);
    chk("flush_alu_held", bus.aluResult_M, 64'd25);
    issue(4'b0010, 64'd1, 64'd1, 64'd0, 64'd0, 1'b0, 2'b00, 2'b00);
    chk("post_flush_alu", bus.aluResult_M, 64'd2);
    chk("post_flush_valid", N'(bus.out_valid_M), 64'd1);

    // Flush coinciding with a presented instruction.
    set_ops(4'b0010, 64'd9, 64'd9, 64'd0, 64'd0, 1'b0, 2'b00, 2'b00);
    bus.in_valid_E = 1'b1;
    bus.flush_E    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_E = 1'b0;
    bus.flush_E    = 1'b0;
    chk("flushv_valid", N'(bus.out_valid_M), 64'd0);
    chk("flushv_alu", bus.aluResult_M, 64'd2);
    repeat (70) @(posedge clk);
    #1;
    chk("idle_valid", N'(bus.out_valid_M), 64'd0);

    cmp_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
